usb_in_pkt_writer: RTL and testbench
====================================

USB_IN_PKT_WRITER -- requirements
Module: usb_in_pkt_writer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning staging FIFO depth in words (power of 2, minimum 4).
REQ-002 SHALL have parameter PKT_WORDS, default 256, meaning FX2 IN endpoint packet size in 16-bit words.
REQ-003 SHALL have parameter TIMEOUT, default 1024, meaning idle cycles before a short packet is committed.
REQ-004 SHALL have parameter EP_ADDR, default 2'b10, meaning FIFOADR value for the IN endpoint (EP6).
REQ-005 SHALL have ports: USB_IFCLK in 1, the single clock; RST in 1, synchronous active-high reset.
REQ-006 SHALL have ports: S_DATA in 16, stream word; S_VALID in 1; S_LAST in 1, marks the final word of a message; S_READY out 1.
REQ-007 SHALL have ports: USB_FLAGD in 1, 1 = FX2 IN FIFO not full; USB_ADDR out 2; USB_DATA_OUT out 16; USB_DATA_OE out 1.
REQ-008 SHALL have ports: USB_SLWR out 1, active-low write strobe; USB_PKEND out 1, active-low packet end.

Function
REQ-009 SHALL accept a stream word on every USB_IFCLK edge where S_VALID=1 and S_READY=1, storing {S_LAST, S_DATA} in the staging FIFO.
REQ-010 SHALL drive S_READY=1 exactly when the staging FIFO is not full, with no lookahead.
REQ-011 SHALL drive USB_ADDR=EP_ADDR constantly.
REQ-012 SHALL implement FSM states RUN and PKEND.
REQ-013 In RUN, SHALL drive USB_SLWR=0 combinationally when the FIFO is not empty and USB_FLAGD=1, else 1.
REQ-014 Each write cycle SHALL present the FIFO head word (first-word-fall-through) on USB_DATA_OUT and pop it at that edge.
REQ-015 SHALL drive USB_DATA_OE=1 whenever the state is RUN or PKEND and RST=0.
REQ-016 SHALL keep a word counter 0..PKT_WORDS-1, incrementing per write and wrapping to 0 after word PKT_WORDS-1, because FX2 auto-commits full packets; no PKEND is issued at the wrap.
REQ-017 When the written word carries LAST=1 and the post-increment count is not 0, SHALL transition RUN->PKEND; when the count wraps to 0 on that word, SHALL stay in RUN.
REQ-018 In PKEND, SHALL drive USB_SLWR=1 and drive USB_PKEND=0 for exactly one cycle in which USB_FLAGD=1, then clear the word counter and return to RUN; SHALL wait in PKEND while USB_FLAGD=0.
REQ-019 Outside a qualifying PKEND cycle, SHALL drive USB_PKEND=1.
REQ-020 SHALL never assert USB_SLWR and USB_PKEND low in the same cycle.
REQ-021 SHALL keep S_READY behaviour independent of the FSM state, so pushes continue during PKEND.
REQ-022 When the FIFO is simultaneously pushed and popped while full, SHALL accept the push and pop the head.

Reset
REQ-023 With RST=1 at an edge, SHALL set state RUN, empty the FIFO, and clear the word counter and idle counter.
REQ-024 During and after reset, SHALL drive USB_SLWR=1, USB_PKEND=1 and S_READY=1, with USB_DATA_OE=0 while RST=1.
REQ-025 Reset mid-packet SHALL discard staged words and issue no PKEND.

Configuration
REQ-026 With macro USB_PKEND_TIMEOUT_EN defined, SHALL count consecutive RUN cycles with the FIFO empty and word count > 0, and at TIMEOUT SHALL enter PKEND.
REQ-027 With USB_PKEND_TIMEOUT_EN defined, the idle counter SHALL reset on any write or on a count of 0.
REQ-028 Without USB_PKEND_TIMEOUT_EN, SHALL omit the idle counter; only LAST triggers PKEND.

Structure
REQ-029 SHALL source FX2 endpoint address constants (EP2/4/6/8 = 00/01/10/11) and the state encoding from shared package usb_pkg.
REQ-030 SHALL implement the staging FIFO as sub-module usb_sync_fifo, 17 bits wide, parameterised by DEPTH.

Verification
REQ-031 Push 256 words 0..255 with LAST on word 255 and USB_FLAGD=1 -> 256 SLWR pulses with data 0..255 in order, no PKEND.
REQ-032 Push 10 words with LAST on word 9 -> 10 writes, then one PKEND pulse on the next FLAGD=1 cycle, then word count 0.
REQ-033 Hold USB_FLAGD=0 with DEPTH words pushed -> SLWR stays high, S_READY=0; release FLAGD -> writes resume with no word lost.
REQ-034 With USB_PKEND_TIMEOUT_EN, push 3 words without LAST and then idle -> PKEND asserted exactly TIMEOUT cycles after the last write.
REQ-035 Assert RST after 5 of 8 words -> no further SLWR/PKEND; the next message starts at word count 0.
REQ-036 Send LAST, then USB_FLAGD=0 for 20 cycles -> PKEND held off; it pulses once, one cycle, when FLAGD returns to 1.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared FX2 definitions: slave-FIFO endpoint addresses, the IN writer state
// encoding and the staging word width.
package usb_pkg;

  localparam logic [1:0] FX2_EP2 = 2'b00;
  localparam logic [1:0] FX2_EP4 = 2'b01;
  localparam logic [1:0] FX2_EP6 = 2'b10;
  localparam logic [1:0] FX2_EP8 = 2'b11;

  // Staging word is {last, data[15:0]}.
  localparam int FIFO_W = 17;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_PKEND = 1'b1
  } wr_state_e;

endpackage

// File: rtl/usb_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; DEPTH must be a power of 2.
// A push into a full FIFO is accepted when a pop happens on the same edge.
module usb_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/usb_in_pkt_writer.sv
// Streams 16-bit words into an FX2 IN endpoint through a staging FIFO and
// closes short packets with PKEND. Define USB_PKEND_TIMEOUT_EN to also commit
// a partial packet after TIMEOUT idle cycles.
module usb_in_pkt_writer
  import usb_pkg::*;
#(
  parameter int         DEPTH     = 16,
  parameter int         PKT_WORDS = 256,
  parameter int         TIMEOUT   = 1024,
  parameter logic [1:0] EP_ADDR   = FX2_EP6
) (
  input  logic        USB_IFCLK,
  input  logic        RST,
  input  logic [15:0] S_DATA,
  input  logic        S_VALID,
  input  logic        S_LAST,
  output logic        S_READY,
  input  logic        USB_FLAGD,
  output logic [1:0]  USB_ADDR,
  output logic [15:0] USB_DATA_OUT,
  output logic        USB_DATA_OE,
  output logic        USB_SLWR,
  output logic        USB_PKEND
);

  localparam int WCW = $clog2(PKT_WORDS);

  wr_state_e         state;
  wr_state_e         state_next;
  logic [FIFO_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              wr_fire;
  logic              pkend_fire;
  logic              idle_hit;
  logic [WCW-1:0]    word_cnt;
  logic [WCW-1:0]    word_cnt_inc;

  usb_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk     (USB_IFCLK),
    .rst     (RST),
    .wr_en   (S_VALID & ~fifo_full),
    .wr_data ({S_LAST, S_DATA}),
    .rd_en   (wr_fire),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // FX2 commits a full packet on its own, so the count simply wraps.
  assign word_cnt_inc = (word_cnt == WCW'(PKT_WORDS - 1)) ? '0 : word_cnt + 1'b1;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    state_next = state;
    wr_fire    = 1'b0;
    pkend_fire = 1'b0;
    if (!RST) begin
      case (state)
        ST_RUN: begin
          if (!fifo_empty && USB_FLAGD) begin
            wr_fire = 1'b1;
            if (fifo_head[16] && (word_cnt_inc != '0)) state_next = ST_PKEND;
          end else if (idle_hit) begin
            state_next = ST_PKEND;
          end
        end
        ST_PKEND: begin
          if (USB_FLAGD) begin
            pkend_fire = 1'b1;
            state_next = ST_RUN;
          end
        end
        default: state_next = ST_RUN;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge USB_IFCLK) begin
    if (RST) state <= ST_RUN;
    else     state <= state_next;
  end

  always_ff @(posedge USB_IFCLK) begin
    if (RST || pkend_fire) word_cnt <= '0;
    else if (wr_fire)      word_cnt <= word_cnt_inc;
  end

`ifdef USB_PKEND_TIMEOUT_EN
  localparam int IDW = $clog2(TIMEOUT);

  logic [IDW-1:0] idle_cnt;
  logic           idle_cond;

  // Hit one cycle early so PKEND lands exactly TIMEOUT cycles after the last write.
  assign idle_cond = (state == ST_RUN) && fifo_empty && (word_cnt != '0);
  assign idle_hit  = idle_cond && (idle_cnt == IDW'(TIMEOUT - 2));

  always_ff @(posedge USB_IFCLK) begin
    if (RST || wr_fire || (word_cnt == '0)) idle_cnt <= '0;
    else if (idle_cond && !idle_hit)        idle_cnt <= idle_cnt + 1'b1;
  end
`else
  // Timeout disabled: this is constant false, only LAST closes a short packet.
  assign idle_hit = (TIMEOUT < 0);
`endif

  assign S_READY      = ~fifo_full | RST;
  assign USB_ADDR     = EP_ADDR;
  assign USB_DATA_OUT = fifo_head[15:0];
  assign USB_DATA_OE  = ~RST;
  assign USB_SLWR     = ~wr_fire;
  assign USB_PKEND    = ~pkend_fire;

endmodule

// File: tb/tb_usb_in_pkt_writer.sv
// Self-checking bench for usb_in_pkt_writer: a per-cycle vector table followed
// by directed multi-cycle sequences observed through a negedge bus monitor.
module tb_usb_in_pkt_writer;

  localparam int DEPTH     = 16;
  localparam int PKT_WORDS = 256;
  localparam int TIMEOUT   = 1024;

  logic        USB_IFCLK = 1'b0;
  logic        RST       = 1'b1;
  logic [15:0] S_DATA    = '0;
  logic        S_VALID   = 1'b0;
  logic        S_LAST    = 1'b0;
  logic        S_READY;
  logic        USB_FLAGD = 1'b1;
  logic [1:0]  USB_ADDR;
  logic [15:0] USB_DATA_OUT;
  logic        USB_DATA_OE;
  logic        USB_SLWR;
  logic        USB_PKEND;

  always #5 USB_IFCLK = ~USB_IFCLK;

  usb_in_pkt_writer #(
    .DEPTH     (DEPTH),
    .PKT_WORDS (PKT_WORDS),
    .TIMEOUT   (TIMEOUT),
    .EP_ADDR   (2'b10)
  ) dut (
    .USB_IFCLK    (USB_IFCLK),
    .RST          (RST),
    .S_DATA       (S_DATA),
    .S_VALID      (S_VALID),
    .S_LAST       (S_LAST),
    .S_READY      (S_READY),
    .USB_FLAGD    (USB_FLAGD),
    .USB_ADDR     (USB_ADDR),
    .USB_DATA_OUT (USB_DATA_OUT),
    .USB_DATA_OE  (USB_DATA_OE),
    .USB_SLWR     (USB_SLWR),
    .USB_PKEND    (USB_PKEND)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Bus monitor, sampled mid-cycle.
  int          cyc         = 0;
  int          pk_cnt      = 0;
  int          pk_cyc      = -1;
  int          last_wr_cyc = -1;
  int          both_low    = 0;
  logic [15:0] wr_log[$];

  always @(negedge USB_IFCLK) begin
    cyc <= cyc + 1;
    if (!USB_SLWR) begin
      wr_log.push_back(USB_DATA_OUT);
      last_wr_cyc <= cyc;
    end
    if (!USB_PKEND) begin
      pk_cnt <= pk_cnt + 1;
      pk_cyc <= cyc;
    end
    if (!USB_SLWR && !USB_PKEND) both_low <= both_low + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge USB_IFCLK);
      #1;
    end
  endtask

  task automatic push_word(input logic [15:0] d, input logic l);
    logic acc;
    int   guard;
    S_DATA  = d;
    S_LAST  = l;
    S_VALID = 1'b1;
    guard   = 0;
    do begin
      @(negedge USB_IFCLK);
      acc = S_READY;
      @(posedge USB_IFCLK);
      #1;
      guard++;
    end while (!acc && guard < 200);
    S_VALID = 1'b0;
    S_LAST  = 1'b0;
    if (!acc) check("push_accept", {31'b0, acc}, 32'd1);
  endtask

  task automatic wait_writes(input int base, input int n, input int budget);
    int g = 0;
    while ((wr_log.size() - base) < n && g < budget) begin
      tick(1);
      g++;
    end
  endtask

  task automatic check_log(input string name, input int base, input int n,
                           input logic [15:0] start, input logic [15:0] xr);
    int          bad = 0;
    logic [15:0] exp;
    check({name, "_count"}, wr_log.size() - base, n);
    for (int i = 0; i < n && (base + i) < wr_log.size(); i++) begin
      exp = (start + 16'(i)) ^ xr;
      if (wr_log[base + i] !== exp) bad++;
    end
    check({name, "_order"}, bad, 0);
  endtask

  typedef struct {
    logic        rst;
    logic        valid;
    logic        last;
    logic        flagd;
    logic [15:0] data;
    logic        e_slwr;
    logic        e_pkend;
    logic        e_ready;
    logic        e_oe;
    logic [15:0] e_data;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int wb;
    int pb;
    int rel_cyc;

    // rst valid last flagd data   | slwr pkend ready oe data
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h1111, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h1111};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h2222, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h2222};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h3333, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h3333};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h4444, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000};

    RST = 1'b1;
    tick(3);

    for (int i = 0; i < 10; i++) begin
      RST       = tbl[i].rst;
      S_VALID   = tbl[i].valid;
      S_LAST    = tbl[i].last;
      USB_FLAGD = tbl[i].flagd;
      S_DATA    = tbl[i].data;
      @(negedge USB_IFCLK);
      check($sformatf("vec%0d_slwr", i),  {31'b0, USB_SLWR},    {31'b0, tbl[i].e_slwr});
      check($sformatf("vec%0d_pkend", i), {31'b0, USB_PKEND},   {31'b0, tbl[i].e_pkend});
      check($sformatf("vec%0d_ready", i), {31'b0, S_READY},     {31'b0, tbl[i].e_ready});
      check($sformatf("vec%0d_oe", i),    {31'b0, USB_DATA_OE}, {31'b0, tbl[i].e_oe});
      check($sformatf("vec%0d_addr", i),  {30'b0, USB_ADDR},    32'd2);
      if (!tbl[i].e_slwr)
        check($sformatf("vec%0d_data", i), {16'b0, USB_DATA_OUT}, {16'b0, tbl[i].e_data});
      @(posedge USB_IFCLK);
      #1;
    end
    S_VALID = 1'b0;
    S_LAST  = 1'b0;

    // Short message: 10 writes then one PKEND on the very next cycle.
    wb = wr_log.size();
    pb = pk_cnt;
    for (int i = 0; i < 10; i++) push_word(16'h0a00 + 16'(i), i == 9);
    wait_writes(wb, 10, 100);
    tick(5);
    check_log("short", wb, 10, 16'h0a00, 16'h0000);
    check("short_pkend_cnt", pk_cnt - pb, 1);
    check("short_pkend_when", pk_cyc, last_wr_cyc + 1);

    // Full packet with LAST on the wrap word: no PKEND (also proves count restarted at 0).
    wb = wr_log.size();
    pb = pk_cnt;
    for (int i = 0; i < PKT_WORDS; i++) push_word(16'(i), i == PKT_WORDS - 1);
    wait_writes(wb, PKT_WORDS, 200);
    tick(5);
    check_log("full", wb, PKT_WORDS, 16'h0000, 16'h0000);
    check("full_no_pkend", pk_cnt - pb, 0);

    // Endpoint full: FIFO fills, writes stall, then resume losslessly.
    wb = wr_log.size();
    pb = pk_cnt;
    USB_FLAGD = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_word(16'h3300 + 16'(i), 1'b0);
    tick(2);
    @(negedge USB_IFCLK);
    check("stall_ready", {31'b0, S_READY}, 32'd0);
    check("stall_slwr", {31'b0, USB_SLWR}, 32'd1);
    check("stall_no_write", wr_log.size() - wb, 0);
    @(posedge USB_IFCLK);
    #1;
    USB_FLAGD = 1'b1;
    push_word(16'h3300 + 16'(DEPTH), 1'b1);
    wait_writes(wb, DEPTH + 1, 100);
    tick(5);
    check_log("stall", wb, DEPTH + 1, 16'h3300, 16'h0000);
    check("stall_pkend_cnt", pk_cnt - pb, 1);

    // PKEND held off by FLAGD=0, then a single one-cycle pulse on release.
    wb = wr_log.size();
    pb = pk_cnt;
    for (int i = 0; i < 3; i++) push_word(16'h6600 + 16'(i), i == 2);
    begin
      int g = 0;
      while ((wr_log.size() - wb) < 3 && g < 50) begin
        tick(1);
        g++;
      end
    end
    USB_FLAGD = 1'b0;
    tick(20);
    check_log("hold", wb, 3, 16'h6600, 16'h0000);
    check("hold_no_pkend", pk_cnt - pb, 0);
    rel_cyc   = cyc;
    USB_FLAGD = 1'b1;
    tick(4);
    check("hold_pkend_cnt", pk_cnt - pb, 1);
    check("hold_pkend_when", pk_cyc, rel_cyc);

    // Reset mid-message: staged words dropped, no PKEND, count restarts.
    for (int i = 0; i < 5; i++) push_word(16'h5500 + 16'(i), 1'b0);
    wait_writes(wb + 3, 5, 100);
    USB_FLAGD = 1'b0;
    push_word(16'h5505, 1'b0);
    push_word(16'h5506, 1'b0);
    wb  = wr_log.size();
    pb  = pk_cnt;
    RST = 1'b1;
    tick(1);
    @(negedge USB_IFCLK);
    check("rst_ready", {31'b0, S_READY}, 32'd1);
    check("rst_oe", {31'b0, USB_DATA_OE}, 32'd0);
    @(posedge USB_IFCLK);
    #1;
    RST       = 1'b0;
    USB_FLAGD = 1'b1;
    tick(10);
    check("rst_no_write", wr_log.size() - wb, 0);
    check("rst_no_pkend", pk_cnt - pb, 0);
    for (int i = 0; i < PKT_WORDS; i++) push_word(16'(i) ^ 16'h5a5a, i == PKT_WORDS - 1);
    wait_writes(wb, PKT_WORDS, 200);
    tick(5);
    check_log("post_rst", wb, PKT_WORDS, 16'h0000, 16'h5a5a);
    check("post_rst_no_pkend", pk_cnt - pb, 0);

`ifdef USB_PKEND_TIMEOUT_EN
    // Idle timeout closes a partial packet exactly TIMEOUT cycles after the last write.
    wb = wr_log.size();
    pb = pk_cnt;
    for (int i = 0; i < 3; i++) push_word(16'h7700 + 16'(i), 1'b0);
    begin
      int g = 0;
      while ((pk_cnt - pb) == 0 && g < TIMEOUT + 100) begin
        tick(1);
        g++;
      end
    end
    tick(2);
    check_log("timeout", wb, 3, 16'h7700, 16'h0000);
    check("timeout_pkend_cnt", pk_cnt - pb, 1);
    check("timeout_pkend_when", pk_cyc - last_wr_cyc, TIMEOUT);
`endif

    check("never_both_low", both_low, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
